cdc_synchronizer: RTL and testbench
===================================

CDC_SYNCHRONIZER -- requirements
Module: cdc_synchronizer

Interface
REQ-001 Parameter STAGES, default 2: number of flip-flop stages in the synchronizer chain; legal range 1..8.
REQ-002 Parameter WIDTH, default 1: bit width of the synchronized signal; each bit is synchronized independently.
REQ-003 Parameter VERBOSE_DEBUG, default 0: when 1, the simulation-only debug tasks print; when 0, they are silent.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port d, input, WIDTH: asynchronous input to be synchronized into the clk domain.
REQ-007 Port q, output, WIDTH: synchronized value, taken from the last chain stage.
REQ-008 Port toggle, output, WIDTH: per-bit change indicator, q XOR q_prev.
REQ-009 Port rise, output, WIDTH: per-bit q AND NOT q_prev.
REQ-010 Port fall, output, WIDTH: per-bit NOT q AND q_prev.

Function
REQ-011 The chain SHALL be STAGES registers of WIDTH bits; stage 0 samples d; stage n samples stage n-1 each rising clk edge.
REQ-012 q SHALL equal the last stage register, so a d value stable before edge k appears on q after edge k+STAGES-1 (latency STAGES edges).
REQ-013 A history register q_prev SHALL load q every rising clk edge.
REQ-014 toggle, rise and fall SHALL be combinational from q and q_prev, each high for exactly one clock period per corresponding transition of q.
REQ-015 Simultaneous changes on several d bits SHALL propagate with identical latency; no cross-bit coherence is guaranteed.
REQ-016 The module SHALL contain no combinational path from d to any output.
REQ-017 Simulation-only task print_prefix(name, id) SHALL write, without newline, "[<$time>] <name><id>: ".
REQ-018 Simulation-only task print_prefix_sub(name, subid, id) SHALL write, without newline, "[<$time>] <name><id>.<subid>: ".
REQ-019 Both tasks SHALL print only when VERBOSE_DEBUG is 1, and SHALL be excluded from synthesis.
REQ-020 Callers SHALL invoke the tasks hierarchically via the instance name, then follow with their own $display for the message body.

Reset
REQ-021 While reset is low, all chain stages and q_prev SHALL be 0 immediately, regardless of clk.
REQ-022 Consequently q, toggle, rise and fall SHALL all be 0 during reset.
REQ-023 Reset asserted mid-transfer SHALL discard in-flight values; after release, q follows d with the full STAGES latency and no spurious edge pulses.
REQ-024 After reset release with d held at 0, no output SHALL pulse.

Structure
REQ-025 Default STAGES and the debug prefix format strings SHALL live in the shared NoC package, for reuse by tx/rx blocks.
REQ-026 The module SHALL be flat; the debug tasks SHALL sit in one optional sub-module debug_tasks, instantiated inside for printing.
REQ-027 Chain stages SHALL be marked as synchronizer registers (ASYNC_REG / dont-touch attributes) and SHALL not be retimed.

Verification
REQ-028 STAGES=2, WIDTH=1, reset released, d 0->1 before edge 1 -> q=1 after edge 2; toggle=rise=1 between edges 2 and 3 only.
REQ-029 STAGES=3 -> same stimulus gives q=1 after edge 3; d 1->0 later gives a single-cycle fall and toggle pulse.
REQ-030 WIDTH=4, d=4'hA held -> q=4'hA after 2 edges; rise=4'hA for one cycle; toggle=4'h0 afterwards.
REQ-031 d=1 propagating, reset driven low between edges 1 and 2 -> q, toggle, rise, fall = 0 immediately; after release, q=1 two edges later with exactly one rise pulse.
REQ-032 VERBOSE_DEBUG=1, print_prefix_sub("TX",1,3) at time 100 -> "[100] TX3.1: "; VERBOSE_DEBUG=0 -> no output.

Source files
------------

// File: rtl/cdc_synchronizer_pkg.sv
//------------------------------------------------------------------------------
// cdc_synchronizer_pkg : shared synchronizer defaults and debug prefix formats
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cdc_synchronizer_pkg;

  localparam int DEFAULT_STAGES = 2;

  // Arguments: time, name, id  /  time, name, id, subid
  localparam string DBG_PREFIX_FMT     = "[%0d] %s%0d: ";
  localparam string DBG_PREFIX_SUB_FMT = "[%0d] %s%0d.%0d: ";

endpackage

`default_nettype wire

// File: rtl/cdc_synchronizer_debug_tasks.sv
//------------------------------------------------------------------------------
// debug_tasks : simulation-only message prefix helpers, silent unless verbose
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module debug_tasks
  import cdc_synchronizer_pkg::*;
#(
  parameter int VERBOSE_DEBUG = 0
) ();

`ifndef SYNTHESIS
  task automatic print_prefix(input string name, input int id);
    if (VERBOSE_DEBUG == 1) $write(DBG_PREFIX_FMT, $time, name, id);
  endtask

  task automatic print_prefix_sub(input string name, input int subid, input int id);
    if (VERBOSE_DEBUG == 1) $write(DBG_PREFIX_SUB_FMT, $time, name, id, subid);
  endtask
`endif

endmodule

`default_nettype wire

// File: rtl/cdc_synchronizer.sv
//------------------------------------------------------------------------------
// cdc_synchronizer : per-bit multi-flop synchronizer with edge indicators
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cdc_synchronizer
  import cdc_synchronizer_pkg::*;
#(
  parameter int STAGES        = DEFAULT_STAGES,
  parameter int WIDTH         = 1,
  parameter int VERBOSE_DEBUG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] toggle,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Metastability chain: keep every stage adjacent and out of retiming.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] q_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_prev_q <= '0;
    else        q_prev_q <= q;
  end

  assign q      = sync_q[STAGES-1];
  assign toggle = q ^ q_prev_q;
  assign rise   = q & ~q_prev_q;
  assign fall   = ~q & q_prev_q;

  debug_tasks #(.VERBOSE_DEBUG(VERBOSE_DEBUG)) u_dbg ();

endmodule

`default_nettype wire

// File: tb/tb_cdc_synchronizer.sv
//------------------------------------------------------------------------------
// tb_cdc_synchronizer : table, directed and scoreboard checks of cdc_synchronizer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdc_synchronizer;

  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       da;
  logic [3:0] dc;
  logic       qa, ta, ra, fa;
  logic       qb, tb, rb, fb;
  logic [3:0] qc, tc, rc, fc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdc_synchronizer #(.STAGES(2), .WIDTH(1), .VERBOSE_DEBUG(1)) u_a (
    .clk(clk), .reset(reset), .d(da), .q(qa), .toggle(ta), .rise(ra), .fall(fa));
  cdc_synchronizer #(.STAGES(3), .WIDTH(1), .VERBOSE_DEBUG(0)) u_b (
    .clk(clk), .reset(reset), .d(da), .q(qb), .toggle(tb), .rise(rb), .fall(fb));
  cdc_synchronizer #(.STAGES(SC), .WIDTH(4), .VERBOSE_DEBUG(0)) u_c (
    .clk(clk), .reset(reset), .d(dc), .q(qc), .toggle(tc), .rise(rc), .fall(fc));

  // Outputs packed as {q, toggle, rise, fall}
  typedef struct {
    logic       d;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sb_q[$];
  logic [3:0] exp_v, prev_v, rnd;

  initial begin
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b1, 4'b1110, 4'b0000};
    tbl[4]  = '{1'b1, 4'b1000, 4'b1110};
    tbl[5]  = '{1'b0, 4'b1000, 4'b1000};
    tbl[6]  = '{1'b0, 4'b0101, 4'b1000};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0101};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 4'b1110, 4'b0000};
    tbl[11] = '{1'b0, 4'b0101, 4'b1110};
    tbl[12] = '{1'b0, 4'b0000, 4'b0101};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000};

    // Reset held with active inputs across several edges
    reset = 1'b0;
    da    = 1'b1;
    dc    = 4'hF;
    #100;
    u_a.u_dbg.print_prefix_sub("TX", 1, 3);
    $display("debug message body");
    u_b.u_dbg.print_prefix("RX", 7);
    #1;
    chk("reset_a", {qa, ta, ra, fa}, 4'b0000);
    chk("reset_b", {qb, tb, rb, fb}, 4'b0000);
    chk("reset_c", {qc, tc, rc, fc}, 16'h0000);

    @(negedge clk);
    reset = 1'b1;
    da    = 1'b0;
    dc    = 4'h0;

    // Table: d before edge n, outputs just after edge n
    for (int i = 0; i < 14; i++) begin
      da = tbl[i].d;
      tick();
      chk($sformatf("tbl_a[%0d]", i), {qa, ta, ra, fa}, tbl[i].a);
      chk($sformatf("tbl_b[%0d]", i), {qb, tb, rb, fb}, tbl[i].b);
    end

    // Reset between edges 1 and 2 of an in-flight transfer
    da = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_a", {qa, ta, ra, fa}, 4'b0000);
    tick();
    chk("midrst_hold_a", {qa, ta, ra, fa}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_rst_e1", {qa, ta, ra, fa}, 4'b0000);
    tick();
    chk("post_rst_e2", {qa, ta, ra, fa}, 4'b1110);
    tick();
    chk("post_rst_e3", {qa, ta, ra, fa}, 4'b1000);

    // Asynchronous clear while q is high, away from any edge
    #2;
    reset = 1'b0;
    #1;
    chk("async_clr_a", {qa, ta, ra, fa}, 4'b0000);
    chk("async_clr_b", {qb, tb, rb, fb}, 4'b0000);
    @(negedge clk);
    da    = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("quiet_a[%0d]", i), {qa, ta, ra, fa}, 4'b0000);
      chk($sformatf("quiet_b[%0d]", i), {qb, tb, rb, fb}, 4'b0000);
    end

    // Multi-bit pattern held
    dc = 4'hA;
    tick();
    chk("w4_e1_q", qc, 4'h0);
    tick();
    chk("w4_e2", {qc, tc, rc, fc}, {4'hA, 4'hA, 4'hA, 4'h0});
    tick();
    chk("w4_e3", {qc, tc, rc, fc}, {4'hA, 4'h0, 4'h0, 4'h0});

    // Scoreboard with random patterns from a clean reset
    @(negedge clk);
    reset = 1'b0;
    dc    = 4'h0;
    @(negedge clk);
    reset  = 1'b1;
    prev_v = 4'h0;
    for (int i = 0; i < 40; i++) begin
      rnd = 4'($urandom_range(0, 15));
      dc  = rnd;
      sb_q.push_back(rnd);
      tick();
      if (sb_q.size() == SC) begin
        exp_v = sb_q.pop_front();
        chk($sformatf("sb_q[%0d]", i),      qc, exp_v);
        chk($sformatf("sb_toggle[%0d]", i), tc, exp_v ^ prev_v);
        chk($sformatf("sb_rise[%0d]", i),   rc, exp_v & ~prev_v);
        chk($sformatf("sb_fall[%0d]", i),   fc, ~exp_v & prev_v);
        prev_v = exp_v;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
